// File: rtl/mem_arb_pkg.sv
// Shared types for mem_port_arbiter: requester owner, read tag, arbitration
// states and read-latency bounds.
package mem_arb_pkg;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  typedef enum logic {
    DATA_PRI,
    FETCH_FORCED
  } arb_state_e;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 3;

  function automatic int unsigned clamp_lat(input int unsigned lat);
    if (lat < READ_LAT_MIN) return READ_LAT_MIN;
    if (lat > READ_LAT_MAX) return READ_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// READ_LAT-deep shift register of read tags; output stage lines up with
// the memory's read data. Async reset drops every in-flight tag.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned READ_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic busy_o
);

  localparam int unsigned TW = $bits(tag_t);
  localparam logic [TW*READ_LAT-1:0] VALID_MASK = {READ_LAT{2'b10}};

  logic [TW*READ_LAT-1:0] pipe_q, pipe_d;

  if (READ_LAT == 1) begin : g_one
    always_comb pipe_d = tag_i;
  end else begin : g_many
    always_comb pipe_d = {pipe_q[TW*(READ_LAT-1)-1:0], tag_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  always_comb begin
    tag_o  = pipe_q[TW*READ_LAT-1 -: TW];
    busy_o = |(pipe_q & VALID_MASK);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-port synchronous RAM with
// anti-starvation for fetch. Define MEM_ARB_PERF_EN for wait/forced counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait,
  output logic [31:0]       perf_forced
`endif
);

  localparam int unsigned LAT = clamp_lat(READ_LAT);
  localparam int unsigned SW  = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_e    state_q;
  logic [SW-1:0] streak_q, streak_d;
  logic          forced;
  tag_t          tag_in, tag_out;
  logic          unused_addr_bits;

  always_comb unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                   d_addr[31:ADDR_W+2], d_addr[1:0]};

  always_comb begin
    forced    = (state_q == FETCH_FORCED);
    d_gnt     = ~rst & d_req & ~(if_req & forced);
    if_gnt    = ~rst & if_req & ~d_gnt;
    mem_en    = d_gnt | if_gnt;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr = d_addr[ADDR_W+1:2];
      if (d_we) begin
        mem_we    = d_wstrb;
        mem_wdata = d_wdata;
      end
    end else if (if_gnt) begin
      mem_addr = if_addr[ADDR_W+1:2];
    end
    // Stores (including zero-strobe ones) occupy a pipe slot but never respond.
    tag_in.valid = if_gnt | (d_gnt & ~d_we);
    tag_in.owner = d_gnt ? OWNER_D : OWNER_IF;

    if (if_gnt || !if_req)                  streak_d = '0;
    else if (d_gnt && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
    else                                    streak_d = streak_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DATA_PRI;
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
      unique case (state_q)
        DATA_PRI:     if (streak_d == STREAK_MAX) state_q <= FETCH_FORCED;
        FETCH_FORCED: if (if_gnt || !if_req)      state_q <= DATA_PRI;
        default:                                  state_q <= DATA_PRI;
      endcase
    end
  end

  mem_arb_tag_pipe #(.READ_LAT(LAT)) u_tag_pipe (
    .clk_i (clk),
    .rst_i (rst),
    .tag_i (tag_in),
    .tag_o (tag_out),
    .busy_o(busy)
  );

  always_comb begin
    if_rvalid = tag_out.valid & (tag_out.owner == OWNER_IF);
    d_rvalid  = tag_out.valid & (tag_out.owner == OWNER_D);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid  ? mem_rdata : '0;
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_wait_q, perf_d_wait_q, perf_forced_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_wait_q <= '0;
      perf_d_wait_q  <= '0;
      perf_forced_q  <= '0;
    end else begin
      perf_if_wait_q <= perf_if_wait_q + {31'd0, if_req & ~if_gnt};
      perf_d_wait_q  <= perf_d_wait_q  + {31'd0, d_req & ~d_gnt};
      perf_forced_q  <= perf_forced_q  + {31'd0, if_gnt & forced};
    end
  end

  always_comb begin
    perf_if_wait = perf_if_wait_q;
    perf_d_wait  = perf_d_wait_q;
    perf_forced  = perf_forced_q;
  end
`endif

endmodule
